// File: rtl/datapath_bus_if.sv
// Control/observation bundle for the single-bus datapath. The control unit
// (or a bench) drives enables, bus selects, port data and the ALU opcode; the
// datapath returns the current bus value.
interface datapath_bus_if;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [31:0] inPort;
  logic [31:0] MDataIn;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut;

  modport master (
    output enable,
    output busSelect,
    output inPort,
    output MDataIn,
    output MD_Read,
    output Control_Signals,
    input  busMuxOut
  );

  modport slave (
    input  enable,
    input  busSelect,
    input  inPort,
    input  MDataIn,
    input  MD_Read,
    input  Control_Signals,
    output busMuxOut
  );
endinterface

// File: rtl/datapath_bus.sv
// Single-bus 32-bit CPU datapath: R0-R15, HI, LO, PC, IR, MAR, MDR, Y, Z and
// InPort around one shared bus, with a 64-bit-result ALU (A = Y, B = bus).
module datapath_bus (
  input  logic           clk,
  input  logic           clr,
  datapath_bus_if.slave  bus_if
);

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpShr  = 4'h4,
    OpShra = 4'h5,
    OpShl  = 4'h6,
    OpRor  = 4'h7,
    OpRol  = 4'h8,
    OpMul  = 4'h9,
    OpDiv  = 4'hA,
    OpNeg  = 4'hB,
    OpNot  = 4'hC,
    OpInc  = 4'hD
  } alu_op_e;

  // Register file and special registers
  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [31:0] zhi_q, zhi_d;
  logic [31:0] zlo_q, zlo_d;
  logic [31:0] inport_q, inport_d;

  logic [31:0] en;
  logic [31:0] sel;
  logic [31:0] bus;
  logic [31:0] bus_src [24];
  logic        bus_hit;

  assign en  = bus_if.enable;
  assign sel = bus_if.busSelect;
  assign bus_if.busMuxOut = bus;

  // Gather every bus driver in select-bit order
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bus_src[i] = r_q[i];
    end
    bus_src[16] = hi_q;
    bus_src[17] = lo_q;
    bus_src[18] = zhi_q;
    bus_src[19] = zlo_q;
    bus_src[20] = pc_q;
    bus_src[21] = mdr_q;
    bus_src[22] = inport_q;
    bus_src[23] = {{13{ir_q[18]}}, ir_q[18:0]};
  end

  // Priority bus mux: lowest-index asserted select wins, none selected reads 0
  always_comb begin
    bus     = '0;
    bus_hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!bus_hit && sel[i]) begin
        bus     = bus_src[i];
        bus_hit = 1'b1;
      end
    end
  end

  // ALU operand helpers
  logic [4:0]         shamt;
  logic signed [31:0] y_s;
  logic [63:0]        rot_dbl;
  logic [63:0]        ror_full;
  logic [63:0]        rol_full;
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic signed [32:0] div_a, div_b, div_q, div_r;
  logic [63:0]        alu_c;

  assign shamt    = bus[4:0];
  assign y_s      = y_q;
  assign rot_dbl  = {y_q, y_q};
  // Rotating a doubled word: amount 0 naturally returns A unchanged
  assign ror_full = rot_dbl >> shamt;
  assign rol_full = rot_dbl << shamt;
  assign mul_a    = {{32{y_q[31]}}, y_q};
  assign mul_b    = {{32{bus[31]}}, bus};
  assign mul_p    = mul_a * mul_b;
  // 33-bit signed divide keeps -2^31 / -1 well defined before truncation
  assign div_a    = {y_q[31], y_q};
  assign div_b    = {bus[31], bus};
  assign div_q    = (bus == 32'h0) ? 33'sd0 : div_a / div_b;
  assign div_r    = (bus == 32'h0) ? 33'sd0 : div_a % div_b;

  // ALU result; 32-bit operations leave the upper half zero
  always_comb begin
    alu_c = {32'h0, bus};
    unique case (alu_op_e'(bus_if.Control_Signals))
      OpAdd:   alu_c = {32'h0, y_q + bus};
      OpSub:   alu_c = {32'h0, y_q - bus};
      OpAnd:   alu_c = {32'h0, y_q & bus};
      OpOr:    alu_c = {32'h0, y_q | bus};
      OpShr:   alu_c = {32'h0, y_q >> shamt};
      OpShra:  alu_c = {32'h0, 32'(y_s >>> shamt)};
      OpShl:   alu_c = {32'h0, y_q << shamt};
      OpRor:   alu_c = {32'h0, ror_full[31:0]};
      OpRol:   alu_c = {32'h0, rol_full[63:32]};
      OpMul:   alu_c = mul_p;
      OpDiv: begin
        if (bus == 32'h0) begin
          alu_c = {y_q, 32'hFFFF_FFFF};
        end else begin
          alu_c = {div_r[31:0], div_q[31:0]};
        end
      end
      OpNeg:   alu_c = {32'h0, 32'h0 - bus};
      OpNot:   alu_c = {32'h0, ~bus};
      OpInc:   alu_c = {32'h0, bus + 32'h1};
      default: alu_c = {32'h0, bus};
    endcase
  end

  // Next-state: each register loads its source when enabled, else holds
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = en[i] ? bus : r_q[i];
    end
    hi_d     = en[16] ? bus : hi_q;
    lo_d     = en[17] ? bus : lo_q;
    pc_d     = en[20] ? bus : pc_q;
    mdr_d    = en[21] ? (bus_if.MD_Read ? bus_if.MDataIn : bus) : mdr_q;
    inport_d = en[22] ? bus_if.inPort : inport_q;
    ir_d     = en[23] ? bus : ir_q;
    zhi_d    = en[24] ? alu_c[63:32] : zhi_q;
    zlo_d    = en[24] ? alu_c[31:0] : zlo_q;
    mar_d    = en[25] ? bus : mar_q;
    y_d      = en[26] ? bus : y_q;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= '0;
      end
      hi_q     <= '0;
      lo_q     <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      y_q      <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      inport_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= r_d[i];
      end
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      y_q      <= y_d;
      zhi_q    <= zhi_d;
      zlo_q    <= zlo_d;
      inport_q <= inport_d;
    end
  end

  // Spare enable/select bits and discarded arithmetic bits have no function
  logic unused_bits;
  assign unused_bits = ^{en[31:27], en[19:18], sel[31:24], div_q[32], div_r[32],
                         ror_full[63:32], rol_full[31:0]};

endmodule

// File: tb/tb_datapath_bus.sv
// Directed bench for datapath_bus: a table of per-cycle control vectors with
// expected bus values, followed by hand-written clear and MAR sequences.
module tb_datapath_bus;

  logic clk;
  logic clr;

  datapath_bus_if bus_if ();

  datapath_bus dut (
    .clk    (clk),
    .clr    (clr),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] en;
    logic [31:0] sel;
    logic [3:0]  op;
    logic [31:0] mdin;
    logic        mdrd;
    logic [31:0] inp;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;

  function automatic logic [31:0] bt(input int i);
    return 32'h1 << i;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] en, input logic [31:0] sel, input logic [3:0] op,
                     input logic chk, input logic [31:0] exp);
    vec_t v;
    v.en = en; v.sel = sel; v.op = op; v.mdin = '0; v.mdrd = 1'b0; v.inp = '0;
    v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One cycle: MDR <- MDataIn
  task automatic ld_mdr(input logic [31:0] val);
    vec_t v;
    v.en = bt(21); v.sel = '0; v.op = '0; v.mdin = val; v.mdrd = 1'b1; v.inp = '0;
    v.chk = 1'b0; v.exp = '0;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus_if.enable          = v.en;
    bus_if.busSelect       = v.sel;
    bus_if.Control_Signals = v.op;
    bus_if.MDataIn         = v.mdin;
    bus_if.MD_Read         = v.mdrd;
    bus_if.inPort          = v.inp;
  endtask

  initial begin
    vec_t idle;
    n_checks = 0;
    n_errors = 0;
    idle.en = '0; idle.sel = '0; idle.op = '0; idle.mdin = '0; idle.mdrd = 1'b0;
    idle.inp = '0; idle.chk = 1'b0; idle.exp = '0;

    // MDR load path into R2, R3, R1
    ld_mdr(32'h12);
    add(bt(2), bt(21), 4'h0, 1, 32'h12);
    ld_mdr(32'h14);
    add(bt(3), bt(21), 4'h0, 1, 32'h14);
    ld_mdr(32'h18);
    add(bt(1), bt(21), 4'h0, 1, 32'h18);
    add('0, bt(2), 4'h0, 1, 32'h12);
    add('0, bt(1), 4'h0, 1, 32'h18);
    // NOT: Y <- R2, Z <- ~R3
    add(bt(26), bt(2), 4'h0, 1, 32'h12);
    add(bt(24), bt(3), 4'hC, 1, 32'h14);
    add('0, bt(19), 4'h0, 1, 32'hFFFF_FFEB);
    add('0, bt(18), 4'h0, 1, 32'h0);
    // OR with Y = 0x12
    add(bt(24), bt(3), 4'h3, 1, 32'h14);
    add('0, bt(19), 4'h0, 1, 32'h16);
    // Bus priority: R1 beats MDR; empty select reads 0
    ld_mdr(32'hABCD);
    add('0, bt(1) | bt(21), 4'h0, 1, 32'h18);
    add('0, '0, 4'h0, 1, 32'h0);
    // MUL -2 * 3
    ld_mdr(32'hFFFF_FFFE);
    add(bt(26), bt(21), 4'h0, 1, 32'hFFFF_FFFE);
    ld_mdr(32'h3);
    add(bt(24), bt(21), 4'h9, 1, 32'h3);
    add('0, bt(18), 4'h0, 1, 32'hFFFF_FFFF);
    add('0, bt(19), 4'h0, 1, 32'hFFFF_FFFA);
    // DIV -7 / 2, then by 0 (empty bus)
    ld_mdr(32'hFFFF_FFF9);
    add(bt(26), bt(21), 4'h0, 1, 32'hFFFF_FFF9);
    ld_mdr(32'h2);
    add(bt(24), bt(21), 4'hA, 1, 32'h2);
    add('0, bt(19), 4'h0, 1, 32'hFFFF_FFFD);
    add('0, bt(18), 4'h0, 1, 32'hFFFF_FFFF);
    add(bt(24), '0, 4'hA, 1, 32'h0);
    add('0, bt(19), 4'h0, 1, 32'hFFFF_FFFF);
    add('0, bt(18), 4'h0, 1, 32'hFFFF_FFF9);
    // PC increment through Z, MAR captures old PC
    ld_mdr(32'h5);
    add(bt(20), bt(21), 4'h0, 1, 32'h5);
    add(bt(24) | bt(25), bt(20), 4'hD, 1, 32'h5);
    add(bt(20), bt(19), 4'h0, 1, 32'h6);
    add('0, bt(20), 4'h0, 1, 32'h6);
    // Z reloads from its own old Z_LO; R1 reloads itself
    add(bt(24), bt(19), 4'hD, 1, 32'h6);
    add('0, bt(19), 4'h0, 1, 32'h7);
    add(bt(1), bt(1), 4'h0, 1, 32'h18);
    add('0, bt(1), 4'h0, 1, 32'h18);
    // IR sign-extended immediate
    ld_mdr(32'h0007_FFFF);
    add(bt(23), bt(21), 4'h0, 0, 32'h0);
    add('0, bt(23), 4'h0, 1, 32'hFFFF_FFFF);
    ld_mdr(32'h0003_FFFF);
    add(bt(23), bt(21), 4'h0, 0, 32'h0);
    add('0, bt(23), 4'h0, 1, 32'h0003_FFFF);
    // Rotates and shifts on A = 0x80000001
    ld_mdr(32'h8000_0001);
    add(bt(26), bt(21), 4'h0, 1, 32'h8000_0001);
    ld_mdr(32'h4);
    add(bt(24), bt(21), 4'h7, 0, 32'h0);
    add('0, bt(19), 4'h0, 1, 32'h1800_0000);
    add(bt(24), bt(21), 4'h8, 0, 32'h0);
    add('0, bt(19), 4'h0, 1, 32'h0000_0018);
    add(bt(24), bt(21), 4'h5, 0, 32'h0);
    add('0, bt(19), 4'h0, 1, 32'hF800_0000);
    ld_mdr(32'h0);
    add(bt(24), bt(21), 4'h4, 0, 32'h0);
    add('0, bt(19), 4'h0, 1, 32'h8000_0001);
    ld_mdr(32'h1);
    add(bt(24), bt(21), 4'h1, 0, 32'h0);
    add('0, bt(19), 4'h0, 1, 32'h8000_0000);

    // Power-on clear
    clr = 1'b1;
    drive(idle);
    #12;
    clr = 1'b0;
    bus_if.busSelect = bt(1);
    #1;
    check("reset_r1", bus_if.busMuxOut, 32'h0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) check($sformatf("vec%0d", i), bus_if.busMuxOut, vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // InPort capture
    drive(idle);
    bus_if.inPort = 32'hCAFE_0001;
    bus_if.enable = bt(22);
    @(posedge clk);
    #1;
    drive(idle);
    bus_if.busSelect = bt(22);
    #1;
    check("inport", bus_if.busMuxOut, 32'hCAFE_0001);
    check("mar_pc", dut.mar_q, 32'h5);

    // Mid-cycle clear with R1 = 0x18
    bus_if.busSelect = bt(1);
    #1;
    check("pre_clr_r1", bus_if.busMuxOut, 32'h18);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_r1", bus_if.busMuxOut, 32'h0);
    bus_if.busSelect = bt(21);
    #1;
    check("clr_mdr", bus_if.busMuxOut, 32'h0);
    bus_if.busSelect = bt(20);
    #1;
    check("clr_pc", bus_if.busMuxOut, 32'h0);
    bus_if.busSelect = bt(19);
    #1;
    check("clr_zlo", bus_if.busMuxOut, 32'h0);
    bus_if.busSelect = bt(18);
    #1;
    check("clr_zhi", bus_if.busMuxOut, 32'h0);
    check("clr_mar", dut.mar_q, 32'h0);

    // First edge after release loads normally
    #1;
    clr = 1'b0;
    drive(idle);
    bus_if.enable  = bt(21);
    bus_if.MDataIn = 32'h55;
    bus_if.MD_Read = 1'b1;
    @(posedge clk);
    #1;
    drive(idle);
    bus_if.busSelect = bt(21);
    #1;
    check("post_clr_mdr", bus_if.busMuxOut, 32'h55);
    bus_if.busSelect = bt(1);
    #1;
    check("post_clr_r1", bus_if.busMuxOut, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/datapath_bus.md
# datapath_bus

Single-bus 32-bit CPU datapath: sixteen general registers, special registers (HI, LO, PC, IR, MAR, MDR, Y, Z, InPort), a one-hot bus multiplexer and a 64-bit-result ALU. The block is driven by an external control unit, or by a bench acting as one, which asserts one-hot register-enable and bus-select vectors plus a 4-bit ALU opcode each cycle. The shared bus value is exported for observation.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock for all registers.
- `clr`  in  1  asynchronous, active-high reset; clears every register to 0.
- `enable`  in  32  one-hot register load enables. Bit map:
  - 0–15: R0–R15
  - 16: HI, 17: LO
  - 20: PC, 21: MDR, 22: InPort, 23: IR
  - 24: Z (both halves), 25: MAR, 26: Y
  - 18, 19 and 27–31: unused, ignored
- `busSelect`  in  32  one-hot bus-driver select. Bit map:
  - 0–15: R0–R15
  - 16: HI, 17: LO
  - 18: Z_HI, 19: Z_LO
  - 20: PC, 21: MDR, 22: InPort
  - 23: sign-extended IR[18:0]
  - 24–31: unused
- `inPort`  in  32  external input-port data.
- `MDataIn`  in  32  memory read data.
- `MD_Read`  in  1  MDR input mux select: 1 = MDataIn, 0 = bus.
- `Control_Signals`  in  4  ALU operation select.
- `busMuxOut`  out  32  current bus value (combinational).

## Operation
- **Bus**
  - The lowest-index set bit of `busSelect[23:0]` drives the bus; if none is set, the bus is 0.
  - Multiple set bits are legal; the lowest index wins.
- **Register loads**
  - Register i loads the bus on a rising `clk` when `enable[i]` = 1.
  - Multiple enables load simultaneously.
- **MDR:** loads `MD_Read ? MDataIn : bus` when `enable[21]` = 1.
- **InPort:** loads the `inPort` pin when `enable[22]` = 1.
- **IR, MAR, PC, HI, LO, Y:** load the bus when enabled.
- **ALU**
  - A = Y, B = bus, result C is 64 bits.
  - `enable[24]` loads Z_HI = C[63:32] and Z_LO = C[31:0].
  - For 32-bit ops, C[63:32] = 0.
- **Control_Signals encoding:**
  - 0000 ADD: A+B (wraps mod 2^32)
  - 0001 SUB: A−B (wraps)
  - 0010 AND
  - 0011 OR
  - 0100 SHR (logical): A >> B[4:0]
  - 0101 SHRA (arithmetic): A >>> B[4:0]
  - 0110 SHL: A << B[4:0]
  - 0111 ROR by B[4:0]
  - 1000 ROL by B[4:0]
  - 1001 MUL: signed A×B, full 64 bits
  - 1010 DIV: signed, Z_LO = quotient, Z_HI = remainder (sign of dividend)
    - B = 0: quotient 0xFFFFFFFF, remainder = A
  - 1011 NEG: −B
  - 1100 NOT: ~B
  - 1101 INC: B+1
  - 1110, 1111: pass B
- A shift or rotate amount of 0 returns A unchanged.
- R0 is an ordinary register with no hardwired zero.

## Timing
- Bus and ALU are purely combinational; `busMuxOut` follows `busSelect` and register contents within the same cycle.
- Register writes occur on rising `clk`; new values are visible on the bus in the following cycle.
- Register-to-register transfer takes 1 cycle. An ALU op takes 2 cycles: operand→Y, then operand B on bus with Z enabled.
- A register enabled while also driving the bus reloads its own value. Z can be loaded from an ALU op whose B operand is Z_LO (old value used).
- `clr` asserted at any time forces all registers to 0 immediately, independent of `clk`. The bus then reads 0 for any selection.
- On deassertion of `clr`, the first rising edge loads normally.
- There is no handshake; all inputs are sampled at the rising edge with no latency beyond 1 cycle.

## Test plan
- **Reset:** assert `clr` mid-run with R1 = 0x18 → immediately `busSelect[1]` gives `busMuxOut` = 0; MDR, PC, Z all read 0.
- **MDR load path:**
  - Cycle 1: MDataIn = 0x12, MD_Read = 1, enable[21]. Cycle 2: busSelect[21], enable[2].
  - Then busSelect[2] → `busMuxOut` = 0x12.
  - Same for R3 = 0x14 and R1 = 0x18.
- **ALU operations:**
  - NOT: Y ← R2 (0x12); then R3 (0x14) on bus, op 1100, enable[24] → Z_LO = 0xFFFFFFEB, Z_HI = 0.
  - OR: with Y = 0x12 and op 0011 → Z_LO = 0x16.
  - MUL: Y = 0xFFFFFFFE, B = 3, op 1001 → Z_HI = 0xFFFFFFFF, Z_LO = 0xFFFFFFFA.
  - DIV: Y = −7, B = 2, op 1010 → Z_LO = 0xFFFFFFFD, Z_HI = 0xFFFFFFFF.
  - DIV by 0: op 1010 with B = 0 → Z_LO = 0xFFFFFFFF, Z_HI = A.
- **Bus priority:** busSelect = bit1 | bit21 → bus shows R1; busSelect = 0 → bus = 0.
- **PC increment:**
  - PC = 5: busSelect[20], op 1101, enable[24] | enable[25] → MAR = 5, Z_LO = 6.
  - Next cycle: busSelect[19], enable[20] → PC = 6.
- **IR immediate:** IR = 0x0007FFFF, busSelect[23] → bus = 0xFFFFFFFF; IR = 0x0003FFFF → bus = 0x0003FFFF.
